// File: rtl/hdmi_video_gen.sv
// hdmi_video_gen: AXI4-Stream pixels to raster video (data/DE/HSYNC/VSYNC)
// with frame alignment, underflow recovery and framing-error pulses.
// Ports: px_clk_i/rst_i; video_i_* stream sink; px_data_o, de_o, hsync_o,
// vsync_o to the TMDS encoders; underflow_o, sof_err_o, eol_err_o pulses.
module hdmi_video_gen #(
  parameter int PX_WIDTH    = 10,
  parameter int TDATA_WIDTH = 32,
  parameter int H_ACTIVE    = 1920,
  parameter int H_FP        = 88,
  parameter int H_SYNC      = 44,
  parameter int H_BP        = 148,
  parameter int V_ACTIVE    = 1080,
  parameter int V_FP        = 4,
  parameter int V_SYNC      = 5,
  parameter int V_BP        = 36,
  parameter bit HS_POL      = 1'b1,
  parameter bit VS_POL      = 1'b1
) (
  input  logic                   px_clk_i,
  input  logic                   rst_i,
  input  logic [TDATA_WIDTH-1:0] video_i_tdata,
  input  logic                   video_i_tvalid,
  output logic                   video_i_tready,
  input  logic                   video_i_tuser,
  input  logic                   video_i_tlast,
  output logic [3*PX_WIDTH-1:0]  px_data_o,
  output logic                   de_o,
  output logic                   hsync_o,
  output logic                   vsync_o,
  output logic                   underflow_o,
  output logic                   sof_err_o,
  output logic                   eol_err_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  typedef enum logic [1:0] {
    WAIT_SOF,
    WAIT_FRAME,
    STREAM
  } state_t;

  state_t        state;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  logic h_wrap;
  logic v_wrap;
  logic active;
  logic hs;
  logic vs;
  logic sof_pos;
  logic eol_pos;
  logic accept;
  logic uf;
  logic se;
  logic ee;
  logic unused_tdata;

  // Whole bus is reduced so upper bits beyond 3*PX_WIDTH count as used.
  assign unused_tdata = ^video_i_tdata;

  assign h_wrap  = (int'(h_cnt) == H_TOTAL - 1);
  assign v_wrap  = (int'(v_cnt) == V_TOTAL - 1);
  assign active  = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
  assign hs      = (int'(h_cnt) >= H_ACTIVE + H_FP) &&
                   (int'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
  assign vs      = (int'(v_cnt) >= V_ACTIVE + V_FP) &&
                   (int'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC);
  assign sof_pos = (h_cnt == '0) && (v_cnt == '0);
  assign eol_pos = (int'(h_cnt) == H_ACTIVE - 1) && active;

  always_comb begin
    video_i_tready = 1'b0;
    unique case (state)
      WAIT_SOF:   video_i_tready = video_i_tvalid && !video_i_tuser;
      WAIT_FRAME: video_i_tready = sof_pos;
      STREAM:     video_i_tready = active &&
                                   !(video_i_tuser && !sof_pos);
      default:    video_i_tready = 1'b0;
    endcase
  end

  assign accept = video_i_tvalid && video_i_tready;

  assign uf = (state == STREAM) && active && !video_i_tvalid;
  assign se = (state == STREAM) && active && video_i_tvalid &&
              video_i_tuser && !sof_pos;
  // Drained pre-SOF beats are not part of the picture, so no tlast check.
  assign ee = accept && (state != WAIT_SOF) &&
              (video_i_tlast != eol_pos);

  always_ff @(posedge px_clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      state       <= WAIT_SOF;
      px_data_o   <= '0;
      de_o        <= 1'b0;
      hsync_o     <= !HS_POL;
      vsync_o     <= !VS_POL;
      underflow_o <= 1'b0;
      sof_err_o   <= 1'b0;
      eol_err_o   <= 1'b0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      if (h_wrap)
        v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;

      de_o    <= active;
      hsync_o <= hs ? HS_POL : !HS_POL;
      vsync_o <= vs ? VS_POL : !VS_POL;

      if (accept && (state != WAIT_SOF))
        px_data_o <= video_i_tdata[3*PX_WIDTH-1:0];
      else
        px_data_o <= '0;

      underflow_o <= uf;
      sof_err_o   <= se;
      eol_err_o   <= ee;

      unique case (state)
        WAIT_SOF:
          if (video_i_tvalid && video_i_tuser)
            state <= WAIT_FRAME;
        WAIT_FRAME:
          if (sof_pos)
            state <= STREAM;
        STREAM:
          if (uf)
            state <= WAIT_SOF;
          else if (se)
            state <= WAIT_FRAME;
        default:
          state <= WAIT_SOF;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_video_gen.sv
// tb_hdmi_video_gen: directed checks of raster timing, stream alignment,
// underflow, sof/eol errors and async reset on a small 14x7 mode.
module tb_hdmi_video_gen;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;
  logic [29:0] px;
  logic        de;
  logic        hs;
  logic        vs;
  logic        uf;
  logic        se;
  logic        ee;

  always #5 clk = ~clk;

  hdmi_video_gen #(
    .PX_WIDTH(10), .TDATA_WIDTH(32),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .px_clk_i(clk),
    .rst_i(rst),
    .video_i_tdata(tdata),
    .video_i_tvalid(tvalid),
    .video_i_tready(tready),
    .video_i_tuser(tuser),
    .video_i_tlast(tlast),
    .px_data_o(px),
    .de_o(de),
    .hsync_o(hs),
    .vsync_o(vs),
    .underflow_o(uf),
    .sof_err_o(se),
    .eol_err_o(ee)
  );

  typedef struct {
    int          dly;
    logic [31:0] d;
    logic        u;
    logic        l;
  } beat_t;

  typedef struct {
    int         cy;
    logic [2:0] exp;
  } tv_t;

  beat_t       q[$];
  tv_t         tab[15];
  int          c;
  int          total;
  int          bad;
  int          tim_bad;
  logic        acc;
  logic        rdy0;
  logic [29:0] cap[4][32];
  int          ufn[4];
  int          sen[4];
  int          een[4];
  int          uf_at[4];
  int          se_at[4];
  int          ee_at[4][4];
  logic [2:0]  sync_log[200];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic drive();
    if (q.size() > 0 && q[0].dly == 0) begin
      tvalid = 1'b1;
      tdata  = q[0].d;
      tuser  = q[0].u;
      tlast  = q[0].l;
    end else begin
      tvalid = 1'b0;
      tdata  = '0;
      tuser  = 1'b0;
      tlast  = 1'b0;
    end
  endtask

  task automatic clear_cap();
    c = 0;
    tim_bad = 0;
    for (int f = 0; f < 4; f++) begin
      ufn[f] = 0; sen[f] = 0; een[f] = 0;
      uf_at[f] = -1; se_at[f] = -1;
      for (int k = 0; k < 4; k++) ee_at[f][k] = -1;
      for (int i = 0; i < 32; i++) cap[f][i] = '1;
    end
  endtask

  task automatic sample();
    int p, h, v, f, idx;
    logic ed, eh, ev;
    p  = c % FT;
    h  = p % HT;
    v  = p / HT;
    f  = c / FT;
    ed = (h < 8) && (v < 4);
    eh = (h >= 10) && (h < 12);
    ev = (v == 5);
    if (c < 200) sync_log[c] = {de, hs, vs};
    if (de !== ed || hs !== eh || vs !== ev) tim_bad++;
    idx = ed ? v * 8 + h : -1;
    if (f < 4) begin
      if (idx >= 0) cap[f][idx] = px;
      else if (px !== '0) tim_bad++;
      if (uf) begin ufn[f]++; uf_at[f] = idx; end
      if (se) begin sen[f]++; se_at[f] = idx; end
      if (ee) begin
        if (een[f] < 4) ee_at[f][een[f]] = idx;
        een[f]++;
      end
    end
  endtask

  task automatic cyc();
    drive();
    #1 acc = tvalid && tready;
    if (c == 0) rdy0 = tready;
    @(posedge clk);
    if (q.size() > 0) begin
      if (q[0].dly > 0) q[0].dly = q[0].dly - 1;
      else if (acc) void'(q.pop_front());
    end
    #1 sample();
    c++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset(input bit check);
    rst = 1'b1;
    q.delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    if (check) begin
      chk("rst de", de, 0);
      chk("rst hs", hs, 0);
      chk("rst vs", vs, 0);
      chk("rst px", px, 0);
      chk("rst err", {uf, se, ee}, 0);
      chk("rst tready", tready, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_cap();
  endtask

  task automatic push_frame(input int base, input int n, input int dly0,
                            input bit eol_bad);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.dly = (i == 0) ? dly0 : 0;
      b.d   = base + i;
      b.u   = (i == 0);
      b.l   = (i % 8 == 7);
      if (eol_bad && i == 14) b.l = 1'b1;
      if (eol_bad && i == 15) b.l = 1'b0;
      q.push_back(b);
    end
  endtask

  task automatic chk_frame(input string n, input int f, input int base,
                           input int black_from);
    logic [31:0] e;
    for (int i = 0; i < 32; i++) begin
      e = (i >= black_from) ? 0 : base + i;
      chk($sformatf("%s px%0d", n, i), {2'b0, cap[f][i]}, e);
    end
  endtask

  task automatic chk_clean(input string n, input int f);
    chk({n, " errs"}, ufn[f] + sen[f] + een[f], 0);
  endtask

  initial begin
    beat_t g;
    total = 0;
    bad   = 0;
    tab[0]  = '{0,   3'b100};
    tab[1]  = '{7,   3'b100};
    tab[2]  = '{8,   3'b000};
    tab[3]  = '{10,  3'b010};
    tab[4]  = '{11,  3'b010};
    tab[5]  = '{12,  3'b000};
    tab[6]  = '{13,  3'b000};
    tab[7]  = '{14,  3'b100};
    tab[8]  = '{56,  3'b000};
    tab[9]  = '{70,  3'b001};
    tab[10] = '{80,  3'b011};
    tab[11] = '{83,  3'b001};
    tab[12] = '{84,  3'b000};
    tab[13] = '{97,  3'b000};
    tab[14] = '{98,  3'b100};

    // Idle raster
    do_reset(1'b1);
    run(99);
    for (int i = 0; i < 15; i++)
      chk($sformatf("idle sync c%0d", tab[i].cy),
          sync_log[tab[i].cy], tab[i].exp);
    chk_frame("idle", 0, 0, 0);
    chk_clean("idle", 0);
    chk("idle timing", tim_bad, 0);

    // Garbage then one clean frame
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      g = '{0, 32'hAA0 + i, 1'b0, 1'b0};
      q.push_back(g);
    end
    push_frame(0, 32, 0, 1'b0);
    run(196);
    chk_frame("gb f0", 0, 0, 0);
    chk_frame("gb f1", 1, 0, 32);
    chk_clean("gb f0", 0);
    chk_clean("gb f1", 1);
    chk("gb timing", tim_bad, 0);

    // Underflow at pixel 13, then realigned frame
    do_reset(1'b0);
    push_frame(0, 13, 0, 1'b0);
    push_frame(100, 32, 1, 1'b0);
    run(294);
    chk_frame("uf f1", 1, 0, 13);
    chk("uf count", ufn[1], 1);
    chk("uf pos", uf_at[1], 13);
    chk("uf others", sen[1] + een[1], 0);
    chk_frame("uf f2", 2, 100, 32);
    chk_clean("uf f2", 2);
    chk_clean("uf f0", 0);
    chk("uf timing", tim_bad, 0);

    // Early tuser at pixel 20
    do_reset(1'b0);
    push_frame(0, 20, 0, 1'b0);
    push_frame(200, 32, 0, 1'b0);
    run(294);
    chk_frame("se f1", 1, 0, 20);
    chk("se count", sen[1], 1);
    chk("se pos", se_at[1], 20);
    chk("se others", ufn[1] + een[1], 0);
    chk_frame("se f2", 2, 200, 32);
    chk_clean("se f2", 2);
    chk("se timing", tim_bad, 0);

    // tlast on pixel 6 of line 1, missing on pixel 7
    do_reset(1'b0);
    push_frame(0, 32, 0, 1'b1);
    run(196);
    chk_frame("eol f1", 1, 0, 32);
    chk("eol count", een[1], 2);
    chk("eol pos0", ee_at[1][0], 14);
    chk("eol pos1", ee_at[1][1], 15);
    chk("eol others", ufn[1] + sen[1], 0);

    // Async reset mid line 2
    do_reset(1'b0);
    push_frame(0, 32, 0, 1'b0);
    run(130);
    chk("ar pre de", de, 1);
    chk("ar pre px", px, 19);
    #2 rst = 1'b1;
    #1;
    chk("ar de", de, 0);
    chk("ar hs", hs, 0);
    chk("ar vs", vs, 0);
    chk("ar px", px, 0);
    chk("ar err", {uf, se, ee}, 0);
    @(negedge clk);
    q.delete();
    rst = 1'b0;
    clear_cap();
    g = '{0, 32'h155, 1'b0, 1'b0};
    q.push_back(g);
    q.push_back(g);
    run(98);
    chk("ar drain rdy", rdy0, 1);
    chk("ar drained", q.size(), 0);
    chk_frame("ar f0", 0, 0, 0);
    chk_clean("ar f0", 0);
    chk("ar timing", tim_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
